// File: rtl/rr_priority_encoder.sv
// rr_priority_encoder
//   Registered request-to-index encoder. Picks one set bit of an arbitrary
//   request vector, using either fixed lowest-index priority or round-robin
//   priority. The choice is presented as a binary address and a one-hot grant
//   over a valid/ready handshake.
//
// Ports:
//   i_clk    - clock, rising edge
//   i_rst_n  - asynchronous active-low reset
//   iv_req   - request vector, any number of bits may be set
//   i_ready  - downstream accepts the current output when high
//   o_valid  - ov_addr/ov_grant/o_multi hold a valid selection
//   ov_addr  - binary index of the selected request
//   ov_grant - one-hot of the selected request, zero when o_valid=0
//   o_multi  - more than one request bit was set when captured
module rr_priority_encoder #(
    parameter int  p_WIDTH      = 8,
    parameter int  p_RR         = 1,
    localparam int p_ADDR_WIDTH = $clog2(p_WIDTH)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [p_WIDTH-1:0]      iv_req,
    input  logic                    i_ready,
    output logic                    o_valid,
    output logic [p_ADDR_WIDTH-1:0] ov_addr,
    output logic [p_WIDTH-1:0]      ov_grant,
    output logic                    o_multi
);

    logic                    r_valid;
    logic [p_ADDR_WIDTH-1:0] r_addr;
    logic [p_WIDTH-1:0]      r_grant;
    logic                    r_multi;
    logic [p_ADDR_WIDTH-1:0] r_ptr;

    logic                    w_load;
    logic                    w_found;
    logic                    w_multi;
    logic [p_ADDR_WIDTH-1:0] w_sel;
    logic [p_ADDR_WIDTH-1:0] w_idx;

    // The output register only advances when it is empty or being consumed.
    assign w_load  = !r_valid || i_ready;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_multi = |(iv_req & (iv_req - p_WIDTH'(1)));

    // Search starting at the pointer. The wrap is an explicit subtraction so
    // the index stays inside 0..p_WIDTH-1 for non-power-of-two widths.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 0; k < p_WIDTH; k++) begin
            if (int'(r_ptr) + k >= p_WIDTH) begin
                w_idx = p_ADDR_WIDTH'(int'(r_ptr) + k - p_WIDTH);
            end else begin
                w_idx = p_ADDR_WIDTH'(int'(r_ptr) + k);
            end
            if (!w_found && iv_req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_grant <= '0;
            r_multi <= 1'b0;
            r_ptr   <= '0;
        end else if (w_load) begin
            r_valid <= w_found;
            if (w_found) begin
                r_addr  <= w_sel;
                r_grant <= p_WIDTH'(1) << w_sel;
                r_multi <= w_multi;
                // Fixed priority keeps the pointer parked at index 0.
                if (p_RR != 0) begin
                    r_ptr <= (w_sel == p_ADDR_WIDTH'(p_WIDTH - 1)) ? '0
                                                                   : w_sel + p_ADDR_WIDTH'(1);
                end
            end else begin
                r_addr  <= '0;
                r_grant <= '0;
                r_multi <= 1'b0;
            end
        end
    end

    assign o_valid  = r_valid;
    assign ov_addr  = r_addr;
    assign ov_grant = r_grant;
    assign o_multi  = r_multi;

endmodule

// File: doc/rr_priority_encoder.md
Name: rr_priority_encoder

Overview:
- Registered, parametrised successor to the team's combinational binary encoder.
- Accepts an arbitrary (not necessarily one-hot) request vector and selects one active bit, either by fixed lowest-index priority or by round-robin.
- Presents the selected index as a binary address plus a one-hot grant over a valid/ready output handshake.
- Used as the request-to-index stage in front of shared resources: arbiters, DMA channel select, interrupt controllers.

Parameters:
- p_WIDTH, 8, number of request lines; must be >= 2.
- p_RR, 1, 1 = round-robin priority; 0 = fixed priority, index 0 highest.
- p_ADDR_WIDTH, $clog2(p_WIDTH), localparam (derived, not overridable); width of ov_addr.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- iv_req  input  p_WIDTH  request vector; any number of bits may be set.
- i_ready  input  1  downstream accepts the current output when high.
- o_valid  output  1  ov_addr/ov_grant/o_multi hold a valid selection.
- ov_addr  output  p_ADDR_WIDTH  binary index of the selected request.
- ov_grant  output  p_WIDTH  one-hot of the selected request; all zero when o_valid=0.
- o_multi  output  1  more than one iv_req bit was set when the selection was captured.

Behaviour:
- Reset (i_rst_n low, asynchronous, at any time including mid-transfer):
  - o_valid=0, ov_addr=0, ov_grant=0, o_multi=0, round-robin pointer=0.
  - Any pending output is discarded.
- Load condition: load = (!o_valid) || i_ready. The output register updates only on a rising edge where load=1. Otherwise all outputs hold stable; iv_req is ignored while stalled (o_valid=1 && i_ready=0).
- On load:
  - o_valid <= |iv_req.
  - If iv_req==0: o_valid<=0, ov_grant<=0, o_multi<=0, ov_addr<=0, pointer unchanged.
  - Else: sel = first set bit of iv_req found by searching indices ptr, ptr+1, ..., p_WIDTH-1, 0, ..., ptr-1.
  - ov_addr<=sel, ov_grant<=(1<<sel), o_multi<=(popcount(iv_req)>1).
- Pointer:
  - p_RR=1: on every load with iv_req!=0, ptr <= (sel==p_WIDTH-1) ? 0 : sel+1. Wrap is explicit and must be correct for non-power-of-two p_WIDTH; ptr never exceeds p_WIDTH-1.
  - p_RR=0: ptr is constant 0 (fixed priority, lowest index wins).
- Latency: iv_req sampled at edge N appears on the outputs after edge N, i.e. 1 cycle. Back-to-back: with i_ready held high, a new selection is produced every cycle.
- Simultaneous accept and load: at an edge where o_valid=1 and i_ready=1, the current output is consumed and the new selection is captured at the same edge, with no bubble.
- Fairness: p_RR=1 with a constant iv_req having k bits set grants each set bit exactly once in any k consecutive loads.
- One-hot compatibility: a one-hot iv_req gives ov_addr equal to the previous encoder's address, with o_multi=0.
- ov_addr and ov_grant are always mutually consistent, and both are driven from registers (no combinational path from iv_req to outputs).
- i_ready is the only combinational input affecting next state; no combinational path from i_ready to any output.

Test Plan:
- Reset/idle: p_WIDTH=5; assert i_rst_n=0 mid-cycle while o_valid=1 -> outputs 0 immediately (asynchronous), ptr=0; release with iv_req=0 -> o_valid stays 0.
- One-hot sweep: p_WIDTH=5, p_RR=0, i_ready=1; iv_req = 00001, 00010, 00100, 01000, 10000 on successive cycles -> ov_addr = 0,1,2,3,4 one cycle later, o_multi=0, ov_grant equals the input.
- Fixed priority: p_RR=0; iv_req=10110 held for 3 cycles -> ov_addr=1 every cycle, o_multi=1.
- Round-robin wrap: p_WIDTH=5, p_RR=1, i_ready=1, iv_req=10011 held -> ov_addr sequence 0,1,4,0,1,4; ptr wraps 4->0 correctly.
- Stall: p_RR=1, iv_req=00110, i_ready=0 for 4 cycles while iv_req changes to 11000 -> outputs hold ov_addr=1; on i_ready=1 -> next ov_addr=3 (search starts at ptr=2).
- Non-power-of-two / empty: p_WIDTH=6, iv_req=100000 then 000000 -> ov_addr=5, ptr wraps to 0, then o_valid=0 and ov_grant=0.
